cipher_out_unpacker: RTL and testbench
======================================

CIPHER_OUT_UNPACKER -- requirements
Module: cipher_out_unpacker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with the ports below.
- clk  input  1  global clock; all state updates on its rising edge.
- resetN  input  1  synchronous active-low reset.
- core_data  input  128  result block from the cipher core's o_data.
- core_data_valid  input  1  single-cycle pulse from the core's o_data_valid.
- w_ready  input  1  downstream sink accepts w_data this cycle.
- ovf_clear  input  1  clears the sticky overflow flag.
- w_data  output  32  serialized result word.
- w_valid  output  1  w_data holds a valid word.
- w_last  output  1  w_data is word 3 (the final word) of a block.
- buf_space  output  1  at least one block slot is free; the bus master gates i_data_valid with it.
- ovf  output  1  sticky flag: a core result block was dropped.

Function
REQ-002 The block SHALL buffer up to 2 complete 128-bit blocks in a FIFO, with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
REQ-003 When core_data_valid=1 and count<2, the block SHALL write core_data into the slot at the write pointer and advance the write pointer.
REQ-004 Each block SHALL be emitted as 4 words in MSW-first order: word0=[127:96], word1=[95:64], word2=[63:32], word3=[31:0].
REQ-005 The output state machine SHALL have two states, IDLE and SEND, and SHALL hold a 2-bit word index widx.
REQ-006 In IDLE with count>0, the next state SHALL be SEND with widx=0. In IDLE with count=0, the block SHALL stay in IDLE.
REQ-007 In SEND, w_valid SHALL be 1 and w_data SHALL be the word at widx of the head block.
REQ-008 In SEND, the block SHALL advance widx only on w_valid&w_ready.
REQ-009 w_last SHALL equal (state==SEND && widx==3).
REQ-010 On a handshake with widx=3, the block SHALL pop the head block and wrap widx to 0.
REQ-011 After that pop, the block SHALL stay in SEND if the post-pop count>0 and SHALL otherwise return to IDLE; there SHALL be no bubble between back-to-back blocks.
REQ-012 Latency: a block captured at edge N SHALL present word0 with w_valid=1 in the cycle after edge N+1 when the FIFO was empty and idle.
REQ-013 While w_valid=1 and w_ready=0, w_data and w_last SHALL stay stable.
REQ-014 Simultaneous push and pop: when count=2 and the word3 handshake occurs in the same cycle as core_data_valid, the block SHALL accept the new block, count SHALL stay 2, and ovf SHALL NOT be set.
REQ-015 When core_data_valid=1, count=2 and no pop occurs that cycle, the block SHALL drop the block, set ovf=1, and leave the FIFO contents unchanged.
REQ-016 ovf SHALL stay set until ovf_clear=1. If ovf_clear and a new overflow occur in the same cycle, ovf SHALL be 1 (set wins).
REQ-017 buf_space SHALL equal (count<2), taken from registered state only.
REQ-018 The block SHALL never drive w_valid=1 when count=0.

Reset
REQ-019 With resetN=0 at a rising clk edge, the block SHALL set state=IDLE, widx=0, both pointers=0, count=0 and ovf=0.
REQ-020 Reset outputs SHALL be: w_valid=0, w_last=0, w_data=0, buf_space=1, ovf=0. Buffer contents need not be cleared.
REQ-021 A reset asserted mid-block SHALL abort the block with no further words emitted.
REQ-022 A core_data_valid pulse in a reset cycle SHALL be ignored.

Configuration
REQ-023 With macro CIPHER_UNPACK_BSWAP_EN defined, each emitted word SHALL be byte-reversed (w_data[7:0]=word[31:24], w_data[15:8]=word[23:16], and so on).
REQ-024 Without CIPHER_UNPACK_BSWAP_EN, w_data SHALL equal the word unmodified. All timing and handshakes SHALL be identical in both builds.

Verification
REQ-025 Single block, w_ready=1 held: core_data=0x00112233_44556677_8899AABB_CCDDEEFF.
- Required: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles.
- Required: w_last=1 only on 0xCCDDEEFF; word0 appears one cycle after capture.
- With BSWAP built in: first word 0x33221100.
REQ-026 Backpressure: w_ready toggles 1,0,0,1,1,0,1,1.
- Required: exactly 4 handshakes, w_data stable during every stall, order preserved.
REQ-027 Overflow: w_ready=0, three core_data_valid pulses carrying blocks A, B, C.
- Required: buf_space=0 after B; C dropped; ovf=1.
- Then w_ready=1: A and B emitted back-to-back (8 consecutive w_valid cycles), C never appears.
- Then ovf_clear=1: ovf returns to 0.
REQ-028 Push-on-pop boundary: FIFO full, core_data_valid in the same cycle as the word3 handshake of A.
- Required: new block accepted, ovf=0, count stays 2.
REQ-029 Reset mid-block: resetN=0 after word1 is accepted.
- Required: next cycle w_valid=0, buf_space=1, ovf=0.
- A fresh block then starts at word0.

Source files
------------

// File: rtl/cipher_out_unpacker_if.sv
// Bus bundle between the cipher core result path, the unpacker and the word sink.
// The slave modport is the unpacker's view; master is the surrounding environment.
interface cipher_out_unpacker_if;
   logic [127:0] core_data;
   logic         core_data_valid;
   logic         w_ready;
   logic         ovf_clear;
   logic [31:0]  w_data;
   logic         w_valid;
   logic         w_last;
   logic         buf_space;
   logic         ovf;

   modport master (
      output core_data, core_data_valid, w_ready, ovf_clear,
      input  w_data, w_valid, w_last, buf_space, ovf
   );

   modport slave (
      input  core_data, core_data_valid, w_ready, ovf_clear,
      output w_data, w_valid, w_last, buf_space, ovf
   );
endinterface

// File: rtl/cipher_out_unpacker.sv
// Two-deep 128-bit result FIFO serialized MSW-first into 32-bit words with valid/ready.
// Define CIPHER_UNPACK_BSWAP_EN to byte-reverse every emitted word.
module cipher_out_unpacker (
   input  logic                  clk,
   input  logic                  resetN,
   cipher_out_unpacker_if.slave  bus_io
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e       state_q, state_d;
   logic [1:0]   widx_q, widx_d;
   logic [1:0]   count_q, count_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic         ovf_q, ovf_d;
   logic [127:0] buf_q [2];

   logic         handshake;
   logic         pop;
   logic         push;
   logic         drop;
   logic [127:0] head_blk;
   logic [31:0]  head_word;
   logic [31:0]  out_word;

   function automatic logic [31:0] fmt_word(input logic [31:0] w);
`ifdef CIPHER_UNPACK_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
   always_comb begin
      handshake = (state_q == StSend) && bus_io.w_ready;
      pop       = handshake && (widx_q == 2'd3);
      push      = bus_io.core_data_valid && ((count_q < 2'd2) || pop);
      drop      = bus_io.core_data_valid && (count_q == 2'd2) && !pop;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + 2'(push) - 2'(pop);
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus_io.ovf_clear) begin
         ovf_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      widx_d  = widx_q;
      unique case (state_q)
         StIdle: begin
            if (count_q != 2'd0) begin
               state_d = StSend;
               widx_d  = 2'd0;
            end
         end
         StSend: begin
            if (handshake) begin
               widx_d = widx_q + 2'd1;
               // Stay in StSend across the pop whenever another block is queued.
               if (pop && (count_d == 2'd0)) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            widx_d  = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q  <= StIdle;
         widx_q   <= 2'd0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         widx_q   <= widx_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (resetN && push) begin
         buf_q[wr_ptr_q] <= bus_io.core_data;
      end
   end

   always_comb begin
      head_blk = buf_q[rd_ptr_q];
      unique case (widx_q)
         2'd0:    head_word = head_blk[127:96];
         2'd1:    head_word = head_blk[95:64];
         2'd2:    head_word = head_blk[63:32];
         default: head_word = head_blk[31:0];
      endcase
      out_word = (state_q == StSend) ? fmt_word(head_word) : 32'd0;
   end

   assign bus_io.w_data    = out_word;
   assign bus_io.w_valid   = (state_q == StSend);
   assign bus_io.w_last    = (state_q == StSend) && (widx_q == 2'd3);
   assign bus_io.buf_space = (count_q < 2'd2);
   assign bus_io.ovf       = ovf_q;

   a_valid_needs_data: assert property (@(posedge clk) disable iff (!resetN)
      bus_io.w_valid |-> (count_q != 2'd0));
   a_count_range: assert property (@(posedge clk) disable iff (!resetN)
      count_q <= 2'd2);
   a_stall_stable: assert property (@(posedge clk) disable iff (!resetN)
      (bus_io.w_valid && !bus_io.w_ready) |=> ($stable(bus_io.w_data) && $stable(bus_io.w_last)));

endmodule

// File: tb/tb_cipher_out_unpacker.sv
// Directed bench for cipher_out_unpacker: latency, backpressure, overflow, push-on-pop, reset.
module tb_cipher_out_unpacker;

   logic clk;
   logic resetN;
   int   n_checks;
   int   n_errors;

   cipher_out_unpacker_if bus ();

   cipher_out_unpacker dut (
      .clk    (clk),
      .resetN (resetN),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wexp(input logic [127:0] blk, input int i);
      logic [31:0] w;
      w = blk[127 - 32 * i -: 32];
`ifdef CIPHER_UNPACK_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic expect_word(input string tag, input logic [127:0] blk, input int i);
      check_eq($sformatf("%s_valid%0d", tag, i), 128'(bus.w_valid), 128'(1'b1));
      check_eq($sformatf("%s_data%0d", tag, i), 128'(bus.w_data), 128'(wexp(blk, i)));
      check_eq($sformatf("%s_last%0d", tag, i), 128'(bus.w_last), 128'(i == 3));
   endtask

   task automatic wait_valid(input string tag);
      for (int n = 0; n < 8; n++) begin
         if (bus.w_valid) break;
         @(negedge clk);
      end
      check_eq({tag, "_wait_valid"}, 128'(bus.w_valid), 128'(1'b1));
   endtask

   localparam logic [127:0] BlkK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] BlkR = 128'h01020304_05060708_090A0B0C_0D0E0F10;
   localparam logic [127:0] BlkA = 128'hA0000000_A1111111_A2222222_A3333333;
   localparam logic [127:0] BlkB = 128'hB0000000_B1111111_B2222222_B3333333;
   localparam logic [127:0] BlkC = 128'hC0000000_C1111111_C2222222_C3333333;
   localparam logic [127:0] BlkD = 128'hD0000000_D1111111_D2222222_D3333333;
   localparam logic [127:0] BlkE = 128'hE0000000_E1111111_E2222222_E3333333;
   localparam logic [127:0] BlkF = 128'hF0000000_F1111111_F2222222_F3333333;
   localparam logic [127:0] BlkP = 128'h5A5A5A5A_6B6B6B6B_7C7C7C7C_8D8D8D8D;

   int pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
   int idx;
   int hs_seen;

   initial begin
      n_checks = 0;
      n_errors = 0;
      resetN = 1'b0;
      bus.core_data = '0;
      bus.core_data_valid = 1'b0;
      bus.w_ready = 1'b0;
      bus.ovf_clear = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("rst_w_valid", 128'(bus.w_valid), 128'(1'b0));
      check_eq("rst_w_last", 128'(bus.w_last), 128'(1'b0));
      check_eq("rst_w_data", 128'(bus.w_data), 128'(32'd0));
      check_eq("rst_buf_space", 128'(bus.buf_space), 128'(1'b1));
      check_eq("rst_ovf", 128'(bus.ovf), 128'(1'b0));
      resetN = 1'b1;

      // Single block, ready held high
      @(negedge clk);
      bus.core_data = BlkK;
      bus.core_data_valid = 1'b1;
      bus.w_ready = 1'b1;
      @(negedge clk);
      bus.core_data_valid = 1'b0;
      check_eq("t1_latency_idle", 128'(bus.w_valid), 128'(1'b0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expect_word("t1", BlkK, i);
      end
      @(negedge clk);
      check_eq("t1_done_valid", 128'(bus.w_valid), 128'(1'b0));

      // Backpressure pattern
      bus.core_data = BlkR;
      bus.core_data_valid = 1'b1;
      bus.w_ready = 1'b0;
      @(negedge clk);
      bus.core_data_valid = 1'b0;
      wait_valid("t2");
      idx = 0;
      hs_seen = 0;
      for (int k = 0; k < 8; k++) begin
         bus.w_ready = (pat[k] != 0);
         check_eq($sformatf("t2_valid_c%0d", k), 128'(bus.w_valid), 128'(idx < 4));
         if (idx < 4) expect_word("t2", BlkR, idx);
         if (bus.w_valid && pat[k] != 0) hs_seen++;
         if (pat[k] != 0 && idx < 4) idx++;
         @(negedge clk);
      end
      check_eq("t2_handshakes", 128'(hs_seen), 128'(4));
      bus.w_ready = 1'b0;

      // Overflow: A, B fill, C dropped
      bus.core_data = BlkA;
      bus.core_data_valid = 1'b1;
      @(negedge clk);
      check_eq("t3_space_after_a", 128'(bus.buf_space), 128'(1'b1));
      bus.core_data = BlkB;
      @(negedge clk);
      check_eq("t3_space_after_b", 128'(bus.buf_space), 128'(1'b0));
      bus.core_data = BlkC;
      @(negedge clk);
      bus.core_data_valid = 1'b0;
      check_eq("t3_ovf_set", 128'(bus.ovf), 128'(1'b1));
      check_eq("t3_space_full", 128'(bus.buf_space), 128'(1'b0));
      bus.w_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expect_word(k < 4 ? "t3a" : "t3b", k < 4 ? BlkA : BlkB, k % 4);
         @(negedge clk);
      end
      check_eq("t3_c_absent", 128'(bus.w_valid), 128'(1'b0));
      check_eq("t3_ovf_sticky", 128'(bus.ovf), 128'(1'b1));
      bus.ovf_clear = 1'b1;
      @(negedge clk);
      bus.ovf_clear = 1'b0;
      check_eq("t3_ovf_cleared", 128'(bus.ovf), 128'(1'b0));

      // Push in the same cycle as the word3 pop of a full FIFO
      bus.w_ready = 1'b0;
      bus.core_data = BlkA;
      bus.core_data_valid = 1'b1;
      @(negedge clk);
      bus.core_data = BlkB;
      @(negedge clk);
      bus.core_data_valid = 1'b0;
      check_eq("t4_full", 128'(bus.buf_space), 128'(1'b0));
      bus.w_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_word("t4a", BlkA, k);
         if (k == 3) begin
            bus.core_data = BlkD;
            bus.core_data_valid = 1'b1;
         end
         @(negedge clk);
      end
      bus.core_data_valid = 1'b0;
      check_eq("t4_no_ovf", 128'(bus.ovf), 128'(1'b0));
      check_eq("t4_still_full", 128'(bus.buf_space), 128'(1'b0));
      for (int k = 0; k < 8; k++) begin
         expect_word(k < 4 ? "t4b" : "t4d", k < 4 ? BlkB : BlkD, k % 4);
         @(negedge clk);
      end
      check_eq("t4_drained", 128'(bus.w_valid), 128'(1'b0));
      check_eq("t4_space", 128'(bus.buf_space), 128'(1'b1));

      // Reset after word1 accepted; pulse during reset is ignored
      bus.core_data = BlkE;
      bus.core_data_valid = 1'b1;
      @(negedge clk);
      bus.core_data_valid = 1'b0;
      wait_valid("t5");
      expect_word("t5e", BlkE, 0);
      @(negedge clk);
      expect_word("t5e", BlkE, 1);
      @(negedge clk);
      resetN = 1'b0;
      bus.core_data = BlkF;
      bus.core_data_valid = 1'b1;
      @(negedge clk);
      resetN = 1'b1;
      bus.core_data_valid = 1'b0;
      check_eq("t5_rst_valid", 128'(bus.w_valid), 128'(1'b0));
      check_eq("t5_rst_space", 128'(bus.buf_space), 128'(1'b1));
      check_eq("t5_rst_ovf", 128'(bus.ovf), 128'(1'b0));
      check_eq("t5_rst_data", 128'(bus.w_data), 128'(32'd0));
      @(negedge clk);
      check_eq("t5_pulse_ignored", 128'(bus.w_valid), 128'(1'b0));
      bus.core_data = BlkP;
      bus.core_data_valid = 1'b1;
      @(negedge clk);
      bus.core_data_valid = 1'b0;
      wait_valid("t5p");
      for (int k = 0; k < 4; k++) begin
         expect_word("t5p", BlkP, k);
         @(negedge clk);
      end
      check_eq("t5_end_valid", 128'(bus.w_valid), 128'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
